// File: rtl/conbus_rr.sv
// conbus_rr: parametrised shared-bus Wishbone interconnect, NM masters to NS slaves.
// A registered round-robin arbiter picks one owner; the owner's request is
// broadcast to all slaves and cyc/stb are steered by a top-address decode.
// Accesses that hit no slave terminate with a one-cycle error pulse.
// Optional feature macro: CONBUS_RR_TIMEOUT_EN (adds a slave-ack timeout that
// terminates a stalled strobe with an error after TIMEOUT_CYCLES cycles).
module conbus_rr #(
  parameter int NM = 4,
  parameter int NS = 5,
  parameter int S_ADDR_W = 3,
  parameter logic [NS*S_ADDR_W-1:0] S_ADDRS = {3'b101, 3'b100, 3'b010, 3'b001, 3'b000},
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic [NM*32-1:0]  m_dat_i,
  output logic [31:0]       m_dat_o,
  input  logic [NM*32-1:0]  m_adr_i,
  input  logic [NM*3-1:0]   m_cti_i,
  input  logic [NM-1:0]     m_we_i,
  input  logic [NM*4-1:0]   m_sel_i,
  input  logic [NM-1:0]     m_cyc_i,
  input  logic [NM-1:0]     m_stb_i,
  output logic [NM-1:0]     m_ack_o,
  output logic [NM-1:0]     m_err_o,
  input  logic [NS*32-1:0]  s_dat_i,
  output logic [31:0]       s_dat_o,
  output logic [31:0]       s_adr_o,
  output logic [2:0]        s_cti_o,
  output logic [3:0]        s_sel_o,
  output logic              s_we_o,
  output logic [NS-1:0]     s_cyc_o,
  output logic [NS-1:0]     s_stb_o,
  input  logic [NS-1:0]     s_ack_i,
  output logic [NM-1:0]     grant_o
);

  localparam int MW = (NM > 1) ? $clog2(NM) : 1;
  localparam int SW = (NS > 1) ? $clog2(NS) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } state_t;

  state_t          state;
  logic [NM-1:0]   grant;
  logic [MW-1:0]   gidx;      // index of the owner; 0 while idle
  logic [MW-1:0]   ptr;       // last master granted
  logic [MW-1:0]   next_idx;
  logic            owned;
  logic            g_cyc;
  logic            g_stb;
  logic            stb_eff;
  logic            hit;
  logic [SW-1:0]   sidx;
  logic            slv_ack;
  logic            err_r;
  logic            to_hit;

  // Round-robin scan: the requester closest above the pointer (wrapping) wins.
  // Scanning from the far end down lets the nearest candidate overwrite.
  always_comb begin
    next_idx = ptr;
    for (int j = NM; j >= 1; j--) begin
      if (m_cyc_i[(int'(ptr) + j) % NM]) begin
        next_idx = MW'((int'(ptr) + j) % NM);
      end
    end
  end

  // Arbiter FSM: grant is registered, so one bubble cycle separates owners.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= ST_IDLE;
      grant <= '0;
      gidx  <= '0;
      ptr   <= MW'(NM - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (|m_cyc_i) begin
            state <= ST_OWNED;
            grant <= {{(NM-1){1'b0}}, 1'b1} << next_idx;
            gidx  <= next_idx;
            ptr   <= next_idx;
          end
        end
        ST_OWNED: begin
          // Ownership lasts exactly as long as the owner's cyc, so bursts stay whole.
          if (!m_cyc_i[gidx]) begin
            state <= ST_IDLE;
            grant <= '0;
            gidx  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
          gidx  <= '0;
        end
      endcase
    end
  end

  assign grant_o = grant;

  // Request mux from the owner; with no owner, index 0 is muxed and cyc/stb are masked.
  always_comb begin
    owned   = (state == ST_OWNED);
    s_dat_o = m_dat_i[int'(gidx)*32 +: 32];
    s_adr_o = m_adr_i[int'(gidx)*32 +: 32];
    s_cti_o = m_cti_i[int'(gidx)*3 +: 3];
    s_sel_o = m_sel_i[int'(gidx)*4 +: 4];
    s_we_o  = m_we_i[gidx];
    g_cyc   = owned & m_cyc_i[gidx];
    g_stb   = owned & m_stb_i[gidx];
  end

  // Address decode against the packed base table; the lowest matching slave wins.
  always_comb begin
    hit  = 1'b0;
    sidx = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if (s_adr_o[31 -: S_ADDR_W] == S_ADDRS[k*S_ADDR_W +: S_ADDR_W]) begin
        hit  = 1'b1;
        sidx = SW'(k);
      end
    end
  end

  // Slave steering and response return to the owner only.
  always_comb begin
    stb_eff = g_stb & ~to_hit;
    s_cyc_o = '0;
    s_stb_o = '0;
    for (int k = 0; k < NS; k++) begin
      s_cyc_o[k] = g_cyc   & hit & (int'(sidx) == k);
      s_stb_o[k] = stb_eff & hit & (int'(sidx) == k);
    end
    slv_ack       = hit & s_ack_i[sidx];
    m_dat_o       = hit ? s_dat_i[int'(sidx)*32 +: 32] : 32'h0;
    m_ack_o       = '0;
    m_ack_o[gidx] = g_cyc & slv_ack;
    m_err_o       = '0;
    m_err_o[gidx] = err_r | to_hit;
  end

  // Unmapped-address error: one pulse per strobe, even if stb is held a cycle late.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_r <= 1'b0;
    end else begin
      err_r <= g_cyc & g_stb & ~hit & ~err_r;
    end
  end

`ifdef CONBUS_RR_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;

  logic [TW-1:0] to_cnt;
  logic          grant_change;

  assign grant_change = ((state == ST_IDLE) & (|m_cyc_i)) |
                        ((state == ST_OWNED) & ~m_cyc_i[gidx]);
  assign to_hit       = (to_cnt == TW'(TIMEOUT_CYCLES));

  // Stall counter: runs while a mapped strobe waits for ack; the terminal
  // count fires one error pulse and restarts the count.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      to_cnt <= '0;
    end else if (grant_change | slv_ack | err_r | to_hit) begin
      to_cnt <= '0;
    end else if (g_cyc & g_stb & hit) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  // Timeout disabled: a slave that never acks holds the bus. The compare is
  // constant false for any legal TIMEOUT_CYCLES.
  assign to_hit = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_conbus_rr.sv
// tb_conbus_rr: directed bench for conbus_rr (NM=4, NS=5, default slave map).
// Slaves are modelled by a small ack responder with per-slave latency.
module tb_conbus_rr;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic [127:0]  m_dat_i;
  logic [31:0]   m_dat_o;
  logic [127:0]  m_adr_i;
  logic [11:0]   m_cti_i;
  logic [3:0]    m_we_i;
  logic [15:0]   m_sel_i;
  logic [3:0]    m_cyc_i;
  logic [3:0]    m_stb_i;
  logic [3:0]    m_ack_o;
  logic [3:0]    m_err_o;
  logic [159:0]  s_dat_i;
  logic [31:0]   s_dat_o;
  logic [31:0]   s_adr_o;
  logic [2:0]    s_cti_o;
  logic [3:0]    s_sel_o;
  logic          s_we_o;
  logic [4:0]    s_cyc_o;
  logic [4:0]    s_stb_o;
  logic [4:0]    s_ack_i;
  logic [3:0]    grant_o;

  int total = 0;
  int bad   = 0;

  // Slave model: lat[k] cycles of strobe before ack; 0 means never ack.
  int          lat[5];
  int          wcnt[5];
  logic [31:0] sdat[5];
  logic [4:0]  ack_r;

  conbus_rr #(.NM(4), .NS(5), .S_ADDR_W(3), .TIMEOUT_CYCLES(8)) dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_adr_i(m_adr_i), .m_cti_i(m_cti_i),
    .m_we_i(m_we_i), .m_sel_i(m_sel_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_ack_o(m_ack_o), .m_err_o(m_err_o),
    .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_adr_o(s_adr_o), .s_cti_o(s_cti_o),
    .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_ack_i(s_ack_i), .grant_o(grant_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int k = 0; k < 5; k++) begin
      if (sys_rst) begin
        ack_r[k] <= 1'b0;
        wcnt[k]  <= 0;
      end else if (s_cyc_o[k] && s_stb_o[k] && !ack_r[k]) begin
        ack_r[k] <= (wcnt[k] == lat[k] - 1);
        wcnt[k]  <= (wcnt[k] == lat[k] - 1) ? 0 : wcnt[k] + 1;
      end else begin
        ack_r[k] <= 1'b0;
        wcnt[k]  <= 0;
      end
    end
  end

  assign s_ack_i = ack_r;

  always_comb begin
    s_dat_i = '0;
    for (int k = 0; k < 5; k++) s_dat_i[k*32 +: 32] = sdat[k];
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_m(input int i, input logic req, input logic [31:0] adr, input logic [2:0] cti);
    m_cyc_i[i]          = req;
    m_stb_i[i]          = req;
    m_adr_i[i*32 +: 32] = adr;
    m_cti_i[i*3 +: 3]   = cti;
    m_sel_i[i*4 +: 4]   = 4'hf;
    m_we_i[i]           = 1'b0;
    m_dat_i[i*32 +: 32] = 32'h1000_0000 + i;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    m_dat_i = '0; m_adr_i = '0; m_cti_i = '0; m_we_i = '0;
    m_sel_i = '0; m_cyc_i = '0; m_stb_i = '0;
    for (int k = 0; k < 5; k++) begin
      lat[k]  = 1;
      sdat[k] = 32'h5A00_0000 + k;
    end
    @(negedge clk);
    tick(); tick();
    total++; if (grant_o !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant_o); end
    total++; if (m_ack_o !== 4'b0000) begin bad++; $display("FAIL reset_ack got=%b want=0000", m_ack_o); end
    total++; if (m_err_o !== 4'b0000) begin bad++; $display("FAIL reset_err got=%b want=0000", m_err_o); end
    total++; if (s_cyc_o !== 5'b00000) begin bad++; $display("FAIL reset_scyc got=%b want=00000", s_cyc_o); end
    total++; if (s_stb_o !== 5'b00000) begin bad++; $display("FAIL reset_sstb got=%b want=00000", s_stb_o); end
    sys_rst = 1'b0;
    tick();
  endtask

  // Master 0 reads slave 2 with a 2-cycle ack.
  task automatic test_single_read();
    lat[2]  = 2;
    sdat[2] = 32'hCAFE_BABE;
    set_m(0, 1'b1, 32'h4000_0010, 3'b000);
    tick();
    total++; if (grant_o !== 4'b0001) begin bad++; $display("FAIL rd_grant got=%b want=0001", grant_o); end
    total++; if (s_cyc_o !== 5'b00100) begin bad++; $display("FAIL rd_scyc got=%b want=00100", s_cyc_o); end
    total++; if (s_adr_o !== 32'h4000_0010) begin bad++; $display("FAIL rd_sadr got=%h want=40000010", s_adr_o); end
    total++; if (s_dat_o !== 32'h1000_0000) begin bad++; $display("FAIL rd_sdat got=%h want=10000000", s_dat_o); end
    total++; if (m_ack_o !== 4'b0000) begin bad++; $display("FAIL rd_ack_early1 got=%b want=0000", m_ack_o); end
    tick();
    total++; if (m_ack_o !== 4'b0000) begin bad++; $display("FAIL rd_ack_early2 got=%b want=0000", m_ack_o); end
    tick();
    total++; if (m_ack_o !== 4'b0001) begin bad++; $display("FAIL rd_ack got=%b want=0001", m_ack_o); end
    total++; if (m_dat_o !== 32'hCAFE_BABE) begin bad++; $display("FAIL rd_data got=%h want=cafebabe", m_dat_o); end
    set_m(0, 1'b0, 32'h0, 3'b000);
    tick();
    total++; if (grant_o !== 4'b0000) begin bad++; $display("FAIL rd_release got=%b want=0000", grant_o); end
  endtask

  // Masters 0,1,3 request together; master 0 re-requests once it has finished.
  task automatic test_round_robin();
    logic [3:0] exp_g[12];
    exp_g = '{4'b0001, 4'b0001, 4'b0000, 4'b0010, 4'b0010, 4'b0000,
              4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0001, 4'b0000};
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    lat[0] = 1;
    set_m(0, 1'b1, 32'h0000_0000, 3'b000);
    set_m(1, 1'b1, 32'h0000_0004, 3'b000);
    set_m(3, 1'b1, 32'h0000_0008, 3'b000);
    for (int n = 0; n < 12; n++) begin
      tick();
      total++;
      if (grant_o !== exp_g[n]) begin
        bad++; $display("FAIL rr_grant step=%0d got=%b want=%b", n, grant_o, exp_g[n]);
      end
      for (int i = 0; i < 4; i++) if (m_ack_o[i]) set_m(i, 1'b0, 32'h0, 3'b000);
      if (n == 2) set_m(0, 1'b1, 32'h0000_000C, 3'b000);
    end
    m_cyc_i = '0; m_stb_i = '0;
    tick();
  endtask

  // Master 1 runs a 4-beat burst while master 2 waits.
  task automatic test_back_to_back();
    int  beats;
    logic got;
    beats = 0;
    set_m(1, 1'b1, 32'h0000_0000, 3'b010);
    tick();
    set_m(2, 1'b1, 32'h0000_0010, 3'b000);
    for (int c = 0; c < 40 && beats < 4; c++) begin
      total++;
      if (grant_o !== 4'b0010) begin bad++; $display("FAIL burst_hold cyc=%0d got=%b want=0010", c, grant_o); end
      if (m_ack_o[1]) begin
        beats++;
        if (beats == 3) m_cti_i[5:3] = 3'b111;
        if (beats == 4) set_m(1, 1'b0, 32'h0, 3'b000);
      end
      if (beats < 4) tick();
    end
    total++; if (beats != 4) begin bad++; $display("FAIL burst_beats got=%0d want=4", beats); end
    tick();
    total++; if (grant_o !== 4'b0000) begin bad++; $display("FAIL burst_bubble got=%b want=0000", grant_o); end
    tick();
    total++; if (grant_o !== 4'b0100) begin bad++; $display("FAIL burst_next got=%b want=0100", grant_o); end
    got = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (m_ack_o !== 4'b0000) begin
        got = 1'b1;
        total++; if (m_ack_o !== 4'b0100) begin bad++; $display("FAIL burst_m2_ack got=%b want=0100", m_ack_o); end
      end
    end
    total++; if (!got) begin bad++; $display("FAIL burst_m2_timeout got=noack want=ack"); end
    set_m(2, 1'b0, 32'h0, 3'b000);
    tick();
  endtask

  // Master 2 strobes an unmapped address and holds stb one cycle past the error.
  task automatic test_unmapped();
    set_m(2, 1'b1, 32'h6000_0000, 3'b000);
    tick();
    total++; if (grant_o !== 4'b0100) begin bad++; $display("FAIL um_grant got=%b want=0100", grant_o); end
    total++; if (s_stb_o !== 5'b00000) begin bad++; $display("FAIL um_sstb got=%b want=00000", s_stb_o); end
    total++; if (m_err_o !== 4'b0000) begin bad++; $display("FAIL um_err_early got=%b want=0000", m_err_o); end
    tick();
    total++; if (m_err_o !== 4'b0100) begin bad++; $display("FAIL um_err got=%b want=0100", m_err_o); end
    total++; if (m_ack_o !== 4'b0000) begin bad++; $display("FAIL um_ack got=%b want=0000", m_ack_o); end
    tick();
    total++; if (m_err_o !== 4'b0000) begin bad++; $display("FAIL um_err_once got=%b want=0000", m_err_o); end
    set_m(2, 1'b0, 32'h0, 3'b000);
    tick();
    total++; if (m_err_o !== 4'b0000) begin bad++; $display("FAIL um_err_after got=%b want=0000", m_err_o); end
  endtask

  // Slave 3 never acks.
  task automatic test_timeout();
    int first;
    int errs;
    lat[3] = 0;
    set_m(0, 1'b1, 32'h8000_0000, 3'b000);
    tick();
    total++; if (s_stb_o !== 5'b01000) begin bad++; $display("FAIL to_sstb got=%b want=01000", s_stb_o); end
`ifdef CONBUS_RR_TIMEOUT_EN
    // The sample after the grant edge is stalled cycle 1; the count hits 8 late in the stall.
    first = 0;
    for (int c = 1; c <= 20 && first == 0; c++) begin
      if (m_err_o !== 4'b0000) begin
        first = c;
        total++; if (m_err_o !== 4'b0001) begin bad++; $display("FAIL to_err_vec got=%b want=0001", m_err_o); end
        total++; if (s_stb_o !== 5'b00000) begin bad++; $display("FAIL to_stb_forced got=%b want=00000", s_stb_o); end
      end else begin
        tick();
      end
    end
    total++; if (first < 8 || first > 9) begin bad++; $display("FAIL to_err_cycle got=%0d want=8..9", first); end
    errs = 0;
`else
    first = 0;
    errs  = 0;
    for (int c = 0; c < 2000; c++) begin
      if (m_err_o !== 4'b0000 || m_ack_o !== 4'b0000) errs++;
      tick();
    end
    total++; if (errs != first) begin bad++; $display("FAIL to_no_err got=%0d want=0", errs); end
    total++; if (s_stb_o !== 5'b01000) begin bad++; $display("FAIL to_stalled got=%b want=01000", s_stb_o); end
`endif
    set_m(0, 1'b0, 32'h0, 3'b000);
    tick();
    lat[3] = 1;
  endtask

  // Reset lands in the middle of a master 1 burst.
  task automatic test_reset_mid();
    set_m(1, 1'b1, 32'h0000_0000, 3'b010);
    tick();
    total++; if (grant_o !== 4'b0010) begin bad++; $display("FAIL rm_pre_grant got=%b want=0010", grant_o); end
    tick();
    sys_rst = 1'b1;
    set_m(0, 1'b1, 32'h0000_0020, 3'b000);
    tick();
    total++; if (grant_o !== 4'b0000) begin bad++; $display("FAIL rm_grant got=%b want=0000", grant_o); end
    total++; if (s_cyc_o !== 5'b00000) begin bad++; $display("FAIL rm_scyc got=%b want=00000", s_cyc_o); end
    total++; if (m_ack_o !== 4'b0000) begin bad++; $display("FAIL rm_ack got=%b want=0000", m_ack_o); end
    sys_rst = 1'b0;
    tick();
    total++; if (grant_o !== 4'b0001) begin bad++; $display("FAIL rm_first got=%b want=0001", grant_o); end
    m_cyc_i = '0; m_stb_i = '0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_round_robin();
    test_back_to_back();
    test_unmapped();
    test_timeout();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
